// File: rtl/kbd_ascii_decoder.sv
// PS/2 set-2 scan code to ASCII decoder with prefix FSM, modifier tracking and FWFT output FIFO.
// state   | meaning
// IDLE    | no prefix pending; next byte is a make, F0 or E0
// BRK     | F0 seen; next byte is a break
// EXT     | E0 seen; next byte is an extended make or F0
// EXT_BRK | E0 F0 seen; next byte is an extended break
module kbd_ascii_decoder #(
   parameter int DEPTH     = 8,
   parameter int CNT_W     = 8,
   parameter int REPEAT_EN = 1
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             scan_valid,
   input  logic [7:0]       scan_code,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [7:0]       out_ascii,
   output logic             shift_on,
   output logic             caps_on,
   output logic [CNT_W-1:0] char_count,
   output logic             overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BRK     = 2'd1,
      ST_EXT     = 2'd2,
      ST_EXT_BRK = 2'd3
   } state_t;

   state_t state_q, state_d;
   logic   is_make, is_brk;

   logic   shift_l_q, shift_l_d;
   logic   shift_r_q, shift_r_d;
   logic   caps_q, caps_d;
   logic   caps_held_q, caps_held_d;
   logic [255:0] held_q, held_d;

   logic       is_letter, is_digit, is_spec, mapped;
   logic [4:0] letter_idx;
   logic [3:0] digit_idx;
   logic [7:0] spec_char, digit_shift_char, char_ascii;
   logic       push_req, push_ok, pop, full;

   logic [7:0]       mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic [CNT_W-1:0] char_count_q, char_count_d;
   logic             overflow_q, overflow_d;

   // Prefix FSM
   always_comb begin
      state_d = state_q;
      is_make = 1'b0;
      is_brk  = 1'b0;
      if (scan_valid) begin
         case (state_q)
            ST_IDLE: begin
               if (scan_code == 8'hF0)      state_d = ST_BRK;
               else if (scan_code == 8'hE0) state_d = ST_EXT;
               else                         is_make = 1'b1;
            end
            ST_BRK: begin
               is_brk  = 1'b1;
               state_d = ST_IDLE;
            end
            ST_EXT: begin
               if (scan_code == 8'hF0) state_d = ST_EXT_BRK;
               else                    state_d = ST_IDLE;
            end
            ST_EXT_BRK: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
         endcase
      end
   end

   // Key classification, independent of prefix state
   always_comb begin
      is_letter  = 1'b1;
      letter_idx = 5'd0;
      case (scan_code)
         8'h1C: letter_idx = 5'd0;
         8'h32: letter_idx = 5'd1;
         8'h21: letter_idx = 5'd2;
         8'h23: letter_idx = 5'd3;
         8'h24: letter_idx = 5'd4;
         8'h2B: letter_idx = 5'd5;
         8'h34: letter_idx = 5'd6;
         8'h33: letter_idx = 5'd7;
         8'h43: letter_idx = 5'd8;
         8'h3B: letter_idx = 5'd9;
         8'h42: letter_idx = 5'd10;
         8'h4B: letter_idx = 5'd11;
         8'h3A: letter_idx = 5'd12;
         8'h31: letter_idx = 5'd13;
         8'h44: letter_idx = 5'd14;
         8'h4D: letter_idx = 5'd15;
         8'h15: letter_idx = 5'd16;
         8'h2D: letter_idx = 5'd17;
         8'h1B: letter_idx = 5'd18;
         8'h2C: letter_idx = 5'd19;
         8'h3C: letter_idx = 5'd20;
         8'h2A: letter_idx = 5'd21;
         8'h1D: letter_idx = 5'd22;
         8'h22: letter_idx = 5'd23;
         8'h35: letter_idx = 5'd24;
         8'h1A: letter_idx = 5'd25;
         default: is_letter = 1'b0;
      endcase
   end

   always_comb begin
      is_digit  = 1'b1;
      digit_idx = 4'd0;
      case (scan_code)
         8'h45: digit_idx = 4'd0;
         8'h16: digit_idx = 4'd1;
         8'h1E: digit_idx = 4'd2;
         8'h26: digit_idx = 4'd3;
         8'h25: digit_idx = 4'd4;
         8'h2E: digit_idx = 4'd5;
         8'h36: digit_idx = 4'd6;
         8'h3D: digit_idx = 4'd7;
         8'h3E: digit_idx = 4'd8;
         8'h46: digit_idx = 4'd9;
         default: is_digit = 1'b0;
      endcase
   end

   always_comb begin
      is_spec   = 1'b1;
      spec_char = 8'h00;
      case (scan_code)
         8'h29: spec_char = 8'h20;
         8'h5A: spec_char = 8'h0D;
         8'h66: spec_char = 8'h08;
         default: is_spec = 1'b0;
      endcase
   end

   always_comb begin
      case (digit_idx)
         4'd0:    digit_shift_char = 8'h29;
         4'd1:    digit_shift_char = 8'h21;
         4'd2:    digit_shift_char = 8'h40;
         4'd3:    digit_shift_char = 8'h23;
         4'd4:    digit_shift_char = 8'h24;
         4'd5:    digit_shift_char = 8'h25;
         4'd6:    digit_shift_char = 8'h5E;
         4'd7:    digit_shift_char = 8'h26;
         4'd8:    digit_shift_char = 8'h2A;
         default: digit_shift_char = 8'h28;
      endcase
   end

   assign shift_on = shift_l_q | shift_r_q;
   assign caps_on  = caps_q;
   assign mapped   = is_letter | is_digit | is_spec;

   // Registered modifiers give the pre-byte state for free
   always_comb begin
      char_ascii = spec_char;
      if (is_letter)
         char_ascii = ((shift_on ^ caps_q) ? 8'h41 : 8'h61) + {3'b000, letter_idx};
      else if (is_digit)
         char_ascii = shift_on ? digit_shift_char : (8'h30 + {4'b0000, digit_idx});
   end

   assign push_req = is_make & mapped & ((REPEAT_EN != 0) | ~held_q[scan_code]);

   always_comb begin
      shift_l_d   = shift_l_q;
      shift_r_d   = shift_r_q;
      caps_d      = caps_q;
      caps_held_d = caps_held_q;
      held_d      = held_q;
      if (is_make) begin
         if (scan_code == 8'h12) shift_l_d = 1'b1;
         if (scan_code == 8'h59) shift_r_d = 1'b1;
         if (scan_code == 8'h58) begin
            if (!caps_held_q) caps_d = ~caps_q;
            caps_held_d = 1'b1;
         end
         if (mapped) held_d[scan_code] = 1'b1;
      end
      if (is_brk) begin
         if (scan_code == 8'h12) shift_l_d   = 1'b0;
         if (scan_code == 8'h59) shift_r_d   = 1'b0;
         if (scan_code == 8'h58) caps_held_d = 1'b0;
         if (mapped) held_d[scan_code] = 1'b0;
      end
   end

   // Output FIFO, first-word-fall-through, no empty bypass
   assign out_valid = (cnt_q != '0);
   assign full      = (cnt_q == FULL_CNT);
   assign pop       = out_valid & out_ready;
   assign push_ok   = push_req & (~full | pop);
   assign out_ascii = out_valid ? mem_q[rptr_q] : 8'h00;

   always_comb begin
      wptr_d       = wptr_q;
      rptr_d       = rptr_q;
      cnt_d        = cnt_q;
      char_count_d = char_count_q;
      overflow_d   = overflow_q;
      if (push_ok) begin
         wptr_d       = wptr_q + AW'(1);
         char_count_d = char_count_q + CNT_W'(1);
      end
      if (pop) rptr_d = rptr_q + AW'(1);
      if (push_ok & ~pop)      cnt_d = cnt_q + (AW+1)'(1);
      else if (~push_ok & pop) cnt_d = cnt_q - (AW+1)'(1);
      if (push_req & full & ~pop) overflow_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= char_ascii;
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q      <= ST_IDLE;
         shift_l_q    <= 1'b0;
         shift_r_q    <= 1'b0;
         caps_q       <= 1'b0;
         caps_held_q  <= 1'b0;
         held_q       <= '0;
         wptr_q       <= '0;
         rptr_q       <= '0;
         cnt_q        <= '0;
         char_count_q <= '0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_l_q    <= shift_l_d;
         shift_r_q    <= shift_r_d;
         caps_q       <= caps_d;
         caps_held_q  <= caps_held_d;
         held_q       <= held_d;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         cnt_q        <= cnt_d;
         char_count_q <= char_count_d;
         overflow_q   <= overflow_d;
      end
   end

   assign char_count = char_count_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_kbd_ascii_decoder.sv
// Scoreboard bench: two decoders (typematic repeat on / off) share stimulus; a keyboard model predicts output.
module tb_kbd_ascii_decoder;
   localparam int DEPTH = 4;
   localparam int CNT_W = 4;

   logic clk = 1'b0, clrn = 1'b1, scan_valid = 1'b0, out_ready = 1'b0;
   logic [7:0] scan_code = 8'h00;

   logic             d_valid [2];
   logic [7:0]       d_ascii [2];
   logic             d_shift [2];
   logic             d_caps  [2];
   logic [CNT_W-1:0] d_cc    [2];
   logic             d_ovf   [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   kbd_ascii_decoder #(.DEPTH(DEPTH), .CNT_W(CNT_W), .REPEAT_EN(1)) dut_rep (
      .clk(clk), .clrn(clrn), .scan_valid(scan_valid), .scan_code(scan_code),
      .out_ready(out_ready), .out_valid(d_valid[0]), .out_ascii(d_ascii[0]),
      .shift_on(d_shift[0]), .caps_on(d_caps[0]), .char_count(d_cc[0]), .overflow(d_ovf[0]));

   kbd_ascii_decoder #(.DEPTH(DEPTH), .CNT_W(CNT_W), .REPEAT_EN(0)) dut_norep (
      .clk(clk), .clrn(clrn), .scan_valid(scan_valid), .scan_code(scan_code),
      .out_ready(out_ready), .out_valid(d_valid[1]), .out_ascii(d_ascii[1]),
      .shift_on(d_shift[1]), .caps_on(d_caps[1]), .char_count(d_cc[1]), .overflow(d_ovf[1]));

   // Keyboard reference model
   byte unsigned letter_codes [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
      8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
   byte unsigned digit_codes [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
   string digit_shifted = ")!@#$%^&*(";

   int m_cnt [2];
   int m_cc  [2];
   bit m_ovf [2], m_sl [2], m_sr [2], m_caps [2], m_caps_held [2], m_f0 [2], m_e0 [2];
   bit m_held [2][256];
   logic [7:0] q0 [$];
   logic [7:0] q1 [$];

   function automatic int lookup(input logic [7:0] b, input bit sh, input bit cp);
      for (int i = 0; i < 26; i++)
         if (b == letter_codes[i]) return ((sh ^ cp) ? 65 : 97) + i;
      for (int i = 0; i < 10; i++)
         if (b == digit_codes[i]) return sh ? int'(digit_shifted[i]) : 48 + i;
      if (b == 8'h29) return 32;
      if (b == 8'h5A) return 13;
      if (b == 8'h66) return 8;
      return -1;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 2; r++) begin
         m_cnt[r] = 0; m_cc[r] = 0; m_ovf[r] = 0; m_sl[r] = 0; m_sr[r] = 0;
         m_caps[r] = 0; m_caps_held[r] = 0; m_f0[r] = 0; m_e0[r] = 0;
         for (int k = 0; k < 256; k++) m_held[r][k] = 0;
      end
      q0.delete();
      q1.delete();
   endtask

   task automatic model_make(input int r, input logic [7:0] b);
      int ch;
      if (b == 8'h12) m_sl[r] = 1;
      else if (b == 8'h59) m_sr[r] = 1;
      else if (b == 8'h58) begin
         if (!m_caps_held[r]) m_caps[r] = !m_caps[r];
         m_caps_held[r] = 1;
      end else begin
         ch = lookup(b, m_sl[r] | m_sr[r], m_caps[r]);
         if (ch >= 0) begin
            if (r == 0 || !m_held[r][b]) begin
               if (m_cnt[r] < DEPTH) begin
                  m_cnt[r]++;
                  m_cc[r] = (m_cc[r] + 1) % (1 << CNT_W);
                  if (r == 0) q0.push_back(ch[7:0]); else q1.push_back(ch[7:0]);
               end else m_ovf[r] = 1;
            end
            m_held[r][b] = 1;
         end
      end
   endtask

   task automatic model_byte(input int r, input logic [7:0] b);
      if (m_f0[r]) begin
         if (!m_e0[r]) begin
            if (b == 8'h12) m_sl[r] = 0;
            if (b == 8'h59) m_sr[r] = 0;
            if (b == 8'h58) m_caps_held[r] = 0;
            m_held[r][b] = 0;
         end
         m_f0[r] = 0;
         m_e0[r] = 0;
      end else if (m_e0[r]) begin
         if (b == 8'hF0) m_f0[r] = 1; else m_e0[r] = 0;
      end else if (b == 8'hF0) m_f0[r] = 1;
      else if (b == 8'hE0) m_e0[r] = 1;
      else model_make(r, b);
   endtask

   always @(posedge clk or negedge clrn) begin
      if (!clrn) model_reset();
      else begin
         for (int r = 0; r < 2; r++) begin
            if (m_cnt[r] > 0 && out_ready) m_cnt[r]--;
            if (scan_valid) model_byte(r, scan_code);
         end
      end
   end

   task automatic chk(input string name, input int r, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s dut%0d got %0h expected %0h at %0t", name, r, act, exp, $time);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      logic [7:0] e;
      for (int r = 0; r < 2; r++) begin
         chk("out_valid", r, int'(d_valid[r]), int'(m_cnt[r] != 0));
         chk("char_count", r, int'(d_cc[r]), m_cc[r]);
         chk("overflow", r, int'(d_ovf[r]), int'(m_ovf[r]));
         chk("shift_on", r, int'(d_shift[r]), int'(m_sl[r] | m_sr[r]));
         chk("caps_on", r, int'(d_caps[r]), int'(m_caps[r]));
         if (!clrn) chk("rst_ascii", r, int'(d_ascii[r]), 0);
         if (d_valid[r] && out_ready) begin
            if ((r == 0 ? q0.size() : q1.size()) == 0) begin
               checks++; errors++;
               $display("FAIL pop_unexpected dut%0d got %0h expected none", r, d_ascii[r]);
            end else begin
               e = (r == 0) ? q0.pop_front() : q1.pop_front();
               chk("out_ascii", r, int'(d_ascii[r]), int'(e));
            end
         end
      end
   end

   task automatic send(input logic [7:0] b);
      scan_valid = 1'b1;
      scan_code  = b;
      @(posedge clk); #1;
      scan_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_reset();
      clrn = 1'b0;
      @(posedge clk); #1;
      clrn = 1'b1;
   endtask

   task automatic send_seq(input logic [7:0] s [$]);
      foreach (s[i]) send(s[i]);
   endtask

   byte unsigned pool [] = '{8'h1C,8'h32,8'h21,8'h24,8'h43,8'h1A,8'h35,8'h45,8'h16,8'h3E,8'h46,
      8'h29,8'h5A,8'h66,8'h12,8'h59,8'h58,8'hF0,8'hF0,8'hF0,8'hE0,8'h75,8'h00,8'h0E};

   initial begin
      model_reset();
      #2 clrn = 1'b0;
      #1;
      for (int r = 0; r < 2; r++) begin
         chk("rst_valid", r, int'(d_valid[r]), 0);
         chk("rst_count", r, int'(d_cc[r]), 0);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      clrn = 1'b1;
      out_ready = 1'b1;

      send_seq('{8'h1C, 8'hF0, 8'h1C}); idle(3);
      send_seq('{8'h12, 8'h1C, 8'hF0, 8'h12, 8'h1C}); idle(3);
      send_seq('{8'h58, 8'hF0, 8'h58, 8'h12, 8'h1C, 8'h16, 8'hF0, 8'h12}); idle(3);
      chk("caps_latched", 0, int'(d_caps[0]), 1);
      send_seq('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hF0, 8'h1C}); idle(2);
      chk("ext_no_char", 0, int'(d_cc[0]), 5);
      send(8'h1C); idle(3);

      pulse_reset();
      out_ready = 1'b0;
      repeat (DEPTH + 1) send(8'h1C);
      idle(2);
      chk("ovf_set", 0, int'(d_ovf[0]), 1);
      chk("ovf_count", 0, int'(d_cc[0]), DEPTH);
      chk("norep_count", 1, int'(d_cc[1]), 1);
      out_ready = 1'b1;
      send(8'h1C);
      chk("full_pushpop", 0, int'(d_cc[0]), DEPTH + 1);
      idle(DEPTH + 2);

      pulse_reset();
      send_seq('{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C}); idle(3);
      chk("norep_two", 1, int'(d_cc[1]), 2);
      send(8'hF0);
      pulse_reset();
      send(8'h1C); idle(3);
      chk("prefix_discard", 1, int'(d_cc[1]), 1);

      for (int i = 0; i < 1500; i++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 199) == 0) pulse_reset();
         send(pool[$urandom_range(0, pool.size() - 1)]);
         idle($urandom_range(0, 2));
      end

      out_ready = 1'b1;
      idle(DEPTH + 3);
      chk("drain0", 0, q0.size(), 0);
      chk("drain1", 1, q1.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
